// File: rtl/gpr_file_sb_if.sv
// Register-file access bundle: read/write indices, commit and issue
// controls from the pipeline side; read data and scoreboard status back.
interface gpr_file_sb_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic [ADDR_W-1:0] rs;
    logic [ADDR_W-1:0] rt;
    logic [ADDR_W-1:0] rd;
    logic [1:0]        dst_sel;
    logic              wr_en;
    logic [DATA_W-1:0] wr_data;
    logic              issue_en;
    logic [ADDR_W-1:0] issue_addr;

    logic [DATA_W-1:0] rd_a_data;
    logic [DATA_W-1:0] rd_b_data;
    logic [ADDR_W-1:0] wr_addr;
    logic              busy_a;
    logic              busy_b;
    logic              hazard;
    logic [ADDR_W:0]   busy_cnt;

    modport master (
        output rs, rt, rd, dst_sel, wr_en, wr_data, issue_en, issue_addr,
        input  rd_a_data, rd_b_data, wr_addr, busy_a, busy_b, hazard, busy_cnt
    );

    modport slave (
        input  rs, rt, rd, dst_sel, wr_en, wr_data, issue_en, issue_addr,
        output rd_a_data, rd_b_data, wr_addr, busy_a, busy_b, hazard, busy_cnt
    );
endinterface

// File: rtl/gpr_file_sb.sv
// Parametrised GPR file: two combinational read ports, one synchronous
// write port with rt/rd/link destination select, optional hardwired zero
// register, optional write-to-read bypass and a per-register busy
// scoreboard used by the multicycle control to spot RAW hazards.
module gpr_file_sb #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1,
    parameter int LINK_REG = 2**ADDR_W - 1
) (
    input  logic clk,
    input  logic reset,
    gpr_file_sb_if.slave bus
);
    localparam int NREGS = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] LINK_IDX = ADDR_W'(LINK_REG);
    localparam bit ZERO_EN = (ZERO_REG != 0);
    localparam bit BP_EN   = (BYPASS != 0);

    logic [DATA_W-1:0] regs [NREGS];
    logic [NREGS-1:0]  busy;
    logic [ADDR_W:0]   cnt;

    logic [ADDR_W-1:0] waddr;
    logic              we_eff;
    logic              set_ok;
    logic              set_new;
    logic              clr_new;
    logic              fwd_a;
    logic              fwd_b;

    // Resolve the destination index; the reserved select parks it at 0.
    always_comb begin
        case (bus.dst_sel)
            2'd0:    waddr = bus.rt;
            2'd1:    waddr = bus.rd;
            2'd2:    waddr = LINK_IDX;
            default: waddr = '0;
        endcase
    end

    // Qualify write/issue and work out which busy bits actually toggle, so
    // the population count moves only on real transitions (set beats clear).
    always_comb begin
        we_eff  = bus.wr_en && (bus.dst_sel != 2'd3) && !(ZERO_EN && (waddr == '0));
        set_ok  = bus.issue_en && !(ZERO_EN && (bus.issue_addr == '0));
        set_new = set_ok && !busy[bus.issue_addr];
        clr_new = we_eff && busy[waddr] && !(set_ok && (bus.issue_addr == waddr));
        fwd_a   = BP_EN && we_eff && (waddr == bus.rs);
        fwd_b   = BP_EN && we_eff && (waddr == bus.rt);
    end

    // Read ports: hardwired zero first, then bypass, then stored array.
    always_comb begin
        if (ZERO_EN && (bus.rs == '0))
            bus.rd_a_data = '0;
        else if (fwd_a)
            bus.rd_a_data = bus.wr_data;
        else
            bus.rd_a_data = regs[bus.rs];

        if (ZERO_EN && (bus.rt == '0))
            bus.rd_b_data = '0;
        else if (fwd_b)
            bus.rd_b_data = bus.wr_data;
        else
            bus.rd_b_data = regs[bus.rt];
    end

    // Register array update.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++)
                regs[i] <= '0;
        end else if (we_eff) begin
            regs[waddr] <= bus.wr_data;
        end
    end

    // Scoreboard and busy count; the set is written last so it wins on a
    // same-index collision with a committing write.
    always_ff @(posedge clk) begin
        if (reset) begin
            busy <= '0;
            cnt  <= '0;
        end else begin
            if (we_eff)
                busy[waddr] <= 1'b0;
            if (set_ok)
                busy[bus.issue_addr] <= 1'b1;
            cnt <= cnt + (ADDR_W+1)'(set_new) - (ADDR_W+1)'(clr_new);
        end
    end

    assign bus.wr_addr  = waddr;
    assign bus.busy_a   = busy[bus.rs] && !fwd_a;
    assign bus.busy_b   = busy[bus.rt] && !fwd_b;
    assign bus.hazard   = bus.busy_a || bus.busy_b;
    assign bus.busy_cnt = cnt;

endmodule

// File: tb/tb_gpr_file_sb.sv
// Bench for gpr_file_sb: a bypassing and a non-bypassing instance share
// one stimulus stream and are compared against an array/scoreboard model.
module tb_gpr_file_sb;
    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 32;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic [AW-1:0] t_rs, t_rt, t_rd, t_iaddr;
    logic [1:0]    t_dsel;
    logic          t_wen, t_ien;
    logic [DW-1:0] t_wdata;

    gpr_file_sb_if #(.DATA_W(DW), .ADDR_W(AW)) bus_bp ();
    gpr_file_sb_if #(.DATA_W(DW), .ADDR_W(AW)) bus_nb ();

    assign bus_bp.rs = t_rs;          assign bus_nb.rs = t_rs;
    assign bus_bp.rt = t_rt;          assign bus_nb.rt = t_rt;
    assign bus_bp.rd = t_rd;          assign bus_nb.rd = t_rd;
    assign bus_bp.dst_sel = t_dsel;   assign bus_nb.dst_sel = t_dsel;
    assign bus_bp.wr_en = t_wen;      assign bus_nb.wr_en = t_wen;
    assign bus_bp.wr_data = t_wdata;  assign bus_nb.wr_data = t_wdata;
    assign bus_bp.issue_en = t_ien;   assign bus_nb.issue_en = t_ien;
    assign bus_bp.issue_addr = t_iaddr; assign bus_nb.issue_addr = t_iaddr;

    gpr_file_sb #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(1), .BYPASS(1), .LINK_REG(31))
        dut (.clk(clk), .reset(reset), .bus(bus_bp.slave));
    gpr_file_sb #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(1), .BYPASS(0), .LINK_REG(31))
        dut_nb (.clk(clk), .reset(reset), .bus(bus_nb.slave));

    logic [DW-1:0] m_regs [NR];
    bit            m_busy [NR];
    int errs = 0;
    int checks = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [AW-1:0] m_waddr();
        case (t_dsel)
            2'd0:    return t_rt;
            2'd1:    return t_rd;
            2'd2:    return 5'd31;
            default: return 5'd0;
        endcase
    endfunction

    function automatic bit m_we();
        return t_wen && t_dsel != 2'd3 && m_waddr() != 0;
    endfunction

    function automatic logic [DW-1:0] m_read(input logic [AW-1:0] idx, input bit bp);
        if (idx == 0) return '0;
        if (bp && m_we() && m_waddr() == idx) return t_wdata;
        return m_regs[idx];
    endfunction

    function automatic bit m_busy_out(input logic [AW-1:0] idx, input bit bp);
        return m_busy[idx] && !(bp && m_we() && m_waddr() == idx);
    endfunction

    function automatic int m_cnt();
        int n = 0;
        for (int i = 0; i < NR; i++) n += int'(m_busy[i]);
        return n;
    endfunction

    task automatic drive(input logic [AW-1:0] rs_i, input logic [AW-1:0] rt_i,
                         input logic [AW-1:0] rd_i, input logic [1:0] ds,
                         input logic wen, input logic [DW-1:0] wd,
                         input logic ien, input logic [AW-1:0] ia, input logic rst);
        t_rs = rs_i; t_rt = rt_i; t_rd = rd_i; t_dsel = ds;
        t_wen = wen; t_wdata = wd; t_ien = ien; t_iaddr = ia; reset = rst;
    endtask

    // One clock: check all combinational outputs of both instances, then
    // advance the model by the rules and take the edge.
    task automatic step(input logic [AW-1:0] rs_i, input logic [AW-1:0] rt_i,
                        input logic [AW-1:0] rd_i, input logic [1:0] ds,
                        input logic wen, input logic [DW-1:0] wd,
                        input logic ien, input logic [AW-1:0] ia, input logic rst);
        logic [AW-1:0] wa;
        bit we, ha, hb;
        drive(rs_i, rt_i, rd_i, ds, wen, wd, ien, ia, rst);
        #1;
        check_val("wr_addr", bus_bp.wr_addr, m_waddr());
        check_val("rd_a_bp", bus_bp.rd_a_data, m_read(rs_i, 1));
        check_val("rd_b_bp", bus_bp.rd_b_data, m_read(rt_i, 1));
        check_val("rd_a_nb", bus_nb.rd_a_data, m_read(rs_i, 0));
        check_val("rd_b_nb", bus_nb.rd_b_data, m_read(rt_i, 0));
        check_val("busy_a_bp", bus_bp.busy_a, m_busy_out(rs_i, 1));
        check_val("busy_b_bp", bus_bp.busy_b, m_busy_out(rt_i, 1));
        check_val("busy_a_nb", bus_nb.busy_a, m_busy_out(rs_i, 0));
        check_val("busy_b_nb", bus_nb.busy_b, m_busy_out(rt_i, 0));
        ha = m_busy_out(rs_i, 1) || m_busy_out(rt_i, 1);
        hb = m_busy_out(rs_i, 0) || m_busy_out(rt_i, 0);
        check_val("hazard_bp", bus_bp.hazard, ha);
        check_val("hazard_nb", bus_nb.hazard, hb);
        check_val("busy_cnt_bp", bus_bp.busy_cnt, m_cnt());
        check_val("busy_cnt_nb", bus_nb.busy_cnt, m_cnt());
        wa = m_waddr();
        we = m_we();
        if (rst) begin
            for (int i = 0; i < NR; i++) begin
                m_regs[i] = '0;
                m_busy[i] = 1'b0;
            end
        end else begin
            if (we) begin
                m_regs[wa] = wd;
                m_busy[wa] = 1'b0;
            end
            if (ien && ia != 0) m_busy[ia] = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    // Idle look at stored state against hand-derived constants.
    task automatic peek(input string tag, input logic [AW-1:0] rs_i, input logic [AW-1:0] rt_i,
                        input logic [DW-1:0] ea, input logic [DW-1:0] eb, input int ec);
        drive(rs_i, rt_i, 5'd0, 2'd3, 1'b0, '0, 1'b0, 5'd0, 1'b0);
        #1;
        check_val({tag, "_a"}, bus_bp.rd_a_data, ea);
        check_val({tag, "_b"}, bus_bp.rd_b_data, eb);
        check_val({tag, "_cnt"}, bus_bp.busy_cnt, ec);
    endtask

    function automatic logic [AW-1:0] rand_addr();
        if ($urandom_range(0, 3) == 0) return AW'($urandom_range(0, NR-1));
        return AW'($urandom_range(0, 7));
    endfunction

    initial begin
        for (int i = 0; i < NR; i++) begin
            m_regs[i] = '0;
            m_busy[i] = 1'b0;
        end
        drive(5'd0, 5'd0, 5'd0, 2'd0, 1'b1, 32'hFFFF_FFFF, 1'b1, 5'd3, 1'b1);
        @(posedge clk);
        #1;

        for (int i = 0; i < NR; i++)
            step(AW'(i), AW'(NR-1-i), 5'd0, 2'd3, 1'b0, '0, 1'b0, 5'd0, 1'b0);

        step(5'd5, 5'd0, 5'd5, 2'd1, 1'b1, 32'hDEAD_BEEF, 1'b0, 5'd0, 1'b0);
        peek("after_rd_write", 5'd5, 5'd0, 32'hDEAD_BEEF, 32'h0, 0);
        step(5'd31, 5'd0, 5'd0, 2'd2, 1'b1, 32'h0040_0010, 1'b0, 5'd0, 1'b0);
        step(5'd0, 5'd0, 5'd0, 2'd0, 1'b1, 32'hFFFF_FFFF, 1'b0, 5'd0, 1'b0);
        peek("link_zero", 5'd31, 5'd0, 32'h0040_0010, 32'h0, 0);

        step(5'd0, 5'd0, 5'd0, 2'd3, 1'b0, '0, 1'b1, 5'd7, 1'b0);
        step(5'd7, 5'd0, 5'd0, 2'd3, 1'b0, '0, 1'b0, 5'd0, 1'b0);
        step(5'd7, 5'd7, 5'd0, 2'd0, 1'b1, 32'h1234_5678, 1'b0, 5'd0, 1'b0);
        peek("commit7", 5'd7, 5'd7, 32'h1234_5678, 32'h1234_5678, 0);

        step(5'd0, 5'd0, 5'd0, 2'd3, 1'b0, '0, 1'b1, 5'd9, 1'b0);
        step(5'd9, 5'd9, 5'd0, 2'd0, 1'b1, 32'hAAAA_5555, 1'b1, 5'd9, 1'b0);
        peek("set_wins", 5'd9, 5'd0, 32'hAAAA_5555, 32'h0, 1);
        step(5'd9, 5'd0, 5'd0, 2'd3, 1'b0, '0, 1'b1, 5'd9, 1'b0);
        peek("idem_set", 5'd9, 5'd0, 32'hAAAA_5555, 32'h0, 1);
        step(5'd0, 5'd0, 5'd0, 2'd3, 1'b0, '0, 1'b1, 5'd0, 1'b0);
        peek("zero_issue", 5'd0, 5'd0, 32'h0, 32'h0, 1);

        step(5'd3, 5'd0, 5'd0, 2'd3, 1'b0, '0, 1'b1, 5'd3, 1'b0);
        step(5'd3, 5'd3, 5'd0, 2'd0, 1'b1, 32'h0000_0033, 1'b0, 5'd0, 1'b0);
        step(5'd0, 5'd0, 5'd0, 2'd3, 1'b0, '0, 1'b1, 5'd4, 1'b0);
        step(5'd0, 5'd0, 5'd0, 2'd3, 1'b0, '0, 1'b1, 5'd6, 1'b0);
        step(5'd3, 5'd3, 5'd0, 2'd0, 1'b1, 32'h0000_0099, 1'b1, 5'd5, 1'b1);
        peek("mid_reset", 5'd3, 5'd9, 32'h0, 32'h0, 0);

        for (int n = 0; n < 3000; n++)
            step(rand_addr(), rand_addr(), rand_addr(), 2'($urandom_range(0, 3)),
                 1'($urandom_range(0, 9) < 6), $urandom, 1'($urandom_range(0, 9) < 4),
                 rand_addr(), 1'($urandom_range(0, 79) == 0));

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule

// File: doc/gpr_file_sb.md
Name: gpr_file_sb

Overview:
Parametrised general-purpose register file that succeeds the fixed 32x32 single-write GPR file.
- Two combinational read ports, one synchronous write port.
- Destination select: rt, rd or link register.
- Optional hardwired zero register and write-to-read bypass.
- Per-register busy scoreboard. The multicycle control FSM uses it to detect RAW hazards for in-flight destinations.

Parameters:
DATA_W, 32, register data width in bits
ADDR_W, 5, register index width; register count NREGS = 2**ADDR_W
ZERO_REG, 1, 1 = register 0 always reads 0, ignores writes and is never marked busy
BYPASS, 1, 1 = same-cycle write data is forwarded to read ports and masks the busy flag
LINK_REG, 2**ADDR_W-1, destination index used when dst_sel = 2 (jal)

Ports:
clk  in  1  clock; all state updates on rising edge
reset  in  1  synchronous, active-high
rs  in  ADDR_W  read port A index
rt  in  ADDR_W  read port B index, and write index when dst_sel = 0
rd  in  ADDR_W  write index when dst_sel = 1
dst_sel  in  2  0 = rt, 1 = rd, 2 = LINK_REG, 3 = reserved (no write)
wr_en  in  1  commit wr_data to the selected destination this cycle
wr_data  in  DATA_W  write data
issue_en  in  1  mark issue_addr busy (instruction with pending write issued)
issue_addr  in  ADDR_W  destination being reserved
rd_a_data  out  DATA_W  read data A
rd_b_data  out  DATA_W  read data B
wr_addr  out  ADDR_W  resolved write index (combinational)
busy_a  out  1  rs has a pending write
busy_b  out  1  rt has a pending write
hazard  out  1  busy_a | busy_b
busy_cnt  out  ADDR_W+1  number of registers currently busy

Behaviour:
Reset:
- Reset is synchronous, active-high.
- While reset is sampled high at a rising edge: all NREGS registers <= 0, all busy bits <= 0, busy_cnt <= 0.
- wr_en and issue_en are ignored in that cycle.
- After the reset edge, with no writes, rd_a_data = rd_b_data = 0, busy_a = busy_b = hazard = 0 and busy_cnt = 0.

Write address resolution (combinational):
- wr_addr = rt, rd or LINK_REG according to dst_sel.
- dst_sel = 3 drives wr_addr = 0 and suppresses the write and the busy clear.

Effective write:
- we_eff = wr_en & (dst_sel != 3) & ~(ZERO_REG & wr_addr == 0).
- On a rising edge with we_eff: reg[wr_addr] <= wr_data.
- Write latency is one edge: the value is visible from the stored array in the following cycle.

Read ports (combinational, zero latency):
- rd_a_data = 0 if ZERO_REG & rs == 0.
- Otherwise rd_a_data = wr_data if BYPASS & we_eff & wr_addr == rs.
- Otherwise rd_a_data = reg[rs].
- rd_b_data follows the same rules using rt.
- With BYPASS = 0, a read of a register being written this cycle returns the old value.

Scoreboard (busy[NREGS], registered):
- Set condition: issue_en & ~(ZERO_REG & issue_addr == 0).
- Clear condition: we_eff clears busy[wr_addr].
- Same index set and cleared on one edge: set wins, because a new producer supersedes the committing one.
- Setting an already-busy bit is idempotent.
- Clearing a non-busy bit is a no-op.
- busy_cnt tracks the population count of busy bits. Per edge it changes by -1, 0 or +1 according to actual bit transitions, never counting idempotent ops. It cannot exceed NREGS - ZERO_REG.
- busy_a = busy[rs] & ~(BYPASS & we_eff & wr_addr == rs); busy_b is the same using rt. A committing write resolves the hazard in the same cycle when bypass is enabled.

Register 0 with ZERO_REG = 1:
- Reads 0 and busy[0] is always 0.
- Writes and issues to index 0 are dropped silently.

Reset mid-operation:
- Outstanding busy bits are discarded.
- Any write or issue presented in the reset cycle is lost.

Test Plan:
- Reset, then read all indices -> all reads 0, busy_cnt = 0, hazard = 0.
- dst_sel = 1, rd = 5, wr_en, wr_data = 0xDEADBEEF; same cycle rs = 5 -> rd_a_data = 0xDEADBEEF via bypass; next cycle, with no write, rs = 5 still reads 0xDEADBEEF. With BYPASS = 0, the same-cycle read returns 0.
- dst_sel = 2, wr_en, wr_data = 0x00400010 -> register 31 = 0x00400010. A write to index 0 of 0xFFFFFFFF -> register 0 still reads 0.
- issue_en with issue_addr = 7, then rs = 7 -> busy_a = 1, hazard = 1, busy_cnt = 1. Commit to 7 (dst_sel = 0, rt = 7) -> busy_a = 0 in the commit cycle; busy_cnt = 0 after the edge.
- Same edge: issue_addr = 9 and commit to 9 -> busy[9] remains 1, busy_cnt unchanged at 1. Repeat issue to 9 -> busy_cnt stays 1.
- Issue to indices 3, 4 and 6, assert reset for one cycle with wr_en = 1 to index 3 -> all busy bits 0, register 3 = 0, busy_cnt = 0.
